// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the UART receive baud-tick scheduler.
//   baud_state_e  : controller states (IDLE / RUN / PEND)
//   MIN_DIV       : smallest legal divisor
//   *_DEF         : default parameter values for the top level
package uart_baud_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 17;
  localparam int unsigned DEFAULT_DIV_DEF = 27;
  localparam int unsigned OVERSAMPLE_DEF  = 16;
  localparam int unsigned MIN_DIV         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } baud_state_e;

endpackage

// File: rtl/uart_os_phase_cnt.sv
// Oversample phase counter: counts oversample ticks within one bit and
// raises bit_tick (registered) on the tick that ends the bit.
//   clk, rst_n : clock, synchronous active-low reset
//   tick_in    : an oversample tick is being issued this cycle
//   load_half  : realign phase to mid-bit (count = OVERSAMPLE/2)
//   clear      : force count to 0
//   bit_tick   : registered, aligned with the registered os_tick
module uart_os_phase_cnt
  import uart_baud_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  input  logic load_half,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  logic [OS_W-1:0] os_cnt;

  // Phase count; clear beats realign beats a normal tick.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      os_cnt   <= '0;
      bit_tick <= 1'b0;
    end else if (load_half) begin
      os_cnt   <= OS_W'(OVERSAMPLE / 2);
      bit_tick <= 1'b0;
    end else if (tick_in) begin
      if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
        os_cnt   <= '0;
        bit_tick <= 1'b1;
      end else begin
        os_cnt   <= os_cnt + OS_W'(1);
        bit_tick <= 1'b0;
      end
    end else begin
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud-rate tick scheduler for the UART receive path. Divides clk by a
// runtime-programmable divisor into oversample ticks, and groups those into
// mid-bit-aligned bit ticks. Divisor updates are taken through a
// valid/ready handshake and only applied at a tick boundary.
//   clk, rst_n           : clock, synchronous active-low reset
//   en                   : run enable
//   cfg_valid/cfg_div    : divisor offer;  cfg_ready: offer can be taken
//   cfg_err              : pulse, accepted divisor was < 2 and dropped
//   sync_req             : start edge seen, realign bit phase
//   os_tick / bit_tick   : one-cycle oversample / mid-bit ticks
//   active_div           : divisor in force;  busy: in RUN or PEND
//   div_clk              : debug square wave, only with BAUD_DIVCLK_EN
module uart_baud_ctrl
  import uart_baud_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  input  logic                 sync_req,
  output logic                 os_tick,
  output logic                 bit_tick,
  output logic [CNT_WIDTH-1:0] active_div,
  output logic                 busy
`ifdef BAUD_DIVCLK_EN
  ,
  output logic                 div_clk
`endif
);

  baud_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic [CNT_WIDTH-1:0] active_d;
  logic                 os_tick_d, cfg_err_d, cfg_ready_d, busy_d;
  logic                 tick_c, load_half_c, clear_c;
  logic                 accept_c, legal_c, term_c;

  assign accept_c = cfg_valid && cfg_ready;
  assign legal_c  = cfg_div >= CNT_WIDTH'(MIN_DIV);
  // active_div never drops below 2, so the subtraction cannot wrap.
  assign term_c   = cnt_q == (active_div - CNT_WIDTH'(1));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= CNT_WIDTH'(DEFAULT_DIV);
      active_div <= CNT_WIDTH'(DEFAULT_DIV);
      os_tick    <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      active_div <= active_d;
      os_tick    <= os_tick_d;
      cfg_err    <= cfg_err_d;
      cfg_ready  <= cfg_ready_d;
      busy       <= busy_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    active_d    = active_div;
    os_tick_d   = 1'b0;
    cfg_err_d   = 1'b0;
    tick_c      = 1'b0;
    load_half_c = 1'b0;
    clear_c     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        clear_c = 1'b1;
        if (accept_c) begin
          if (legal_c) active_d  = cfg_div;
          else         cfg_err_d = 1'b1;
        end
        if (en) state_d = RUN;
      end

      RUN, PEND: begin
        if (!en) begin
          // Stop: flush any pending divisor straight into force.
          state_d = IDLE;
          cnt_d   = '0;
          clear_c = 1'b1;
          if (state_q == PEND) active_d = pend_q;
          if (accept_c) begin
            if (legal_c) active_d  = cfg_div;
            else         cfg_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (sync_req) begin
            // Realign suppresses any tick due this cycle.
            cnt_d       = '0;
            load_half_c = 1'b1;
            if (term_c && state_q == PEND) begin
              active_d = pend_q;
              state_d  = RUN;
            end
          end else if (term_c) begin
            cnt_d     = '0;
            os_tick_d = 1'b1;
            tick_c    = 1'b1;
            if (state_q == PEND) begin
              active_d = pend_q;
              state_d  = RUN;
            end
          end
          if (accept_c) begin
            if (legal_c) begin
              pend_d  = cfg_div;
              state_d = PEND;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clear_c = 1'b1;
      end
    endcase

    cfg_ready_d = state_d != PEND;
    busy_d      = state_d != IDLE;
  end

  uart_os_phase_cnt #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_os_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_c),
    .load_half(load_half_c),
    .clear    (clear_c),
    .bit_tick (bit_tick)
  );

`ifdef BAUD_DIVCLK_EN
  // Debug-only square wave: flips at every oversample tick boundary.
  always_ff @(posedge clk) begin
    if (!rst_n)      div_clk <= 1'b0;
    else if (tick_c) div_clk <= ~div_clk;
  end
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Self-checking bench for uart_baud_ctrl (DEFAULT_DIV=4, OVERSAMPLE=4).
// A schedule-based reference model (absolute cycle of the next tick,
// ticks left until the bit tick) is checked every cycle, alongside a few
// hand-computed directed expectations.
module tb_uart_baud_ctrl;

  localparam int unsigned CW  = 17;
  localparam int unsigned DEF = 4;
  localparam int unsigned OS  = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          cfg_valid;
  logic [CW-1:0] cfg_div;
  logic          cfg_ready;
  logic          cfg_err;
  logic          sync_req;
  logic          os_tick;
  logic          bit_tick;
  logic [CW-1:0] active_div;
  logic          busy;
`ifdef BAUD_DIVCLK_EN
  logic          div_clk;
`endif

  uart_baud_ctrl #(
    .CNT_WIDTH  (CW),
    .DEFAULT_DIV(DEF),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .sync_req  (sync_req),
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .active_div(active_div),
    .busy      (busy)
`ifdef BAUD_DIVCLK_EN
    ,
    .div_clk   (div_clk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  int          cyc = 0;
  bit          m_run = 0;
  bit          m_pv = 0;
  int          m_pend = 0;
  int          m_div = DEF;
  int          m_next = 0;
  int          m_left = OS;
  bit          e_os = 0, e_bit = 0, e_err = 0, e_ready = 1, e_busy = 0, e_dclk = 0;
  bit          prev_ready, acc, legal;

  always @(posedge clk) begin
    cyc++;
    prev_ready = e_ready;
    e_os = 0; e_bit = 0; e_err = 0;
    if (!rst_n) begin
      m_run = 0; m_pv = 0; m_div = DEF;
      e_ready = 1; e_busy = 0; e_dclk = 0;
    end else begin
      acc   = cfg_valid && prev_ready;
      legal = int'(cfg_div) >= 2;
      if (!m_run) begin
        if (acc) begin
          if (legal) m_div = int'(cfg_div); else e_err = 1;
        end
        if (en) begin
          m_run  = 1;
          m_next = cyc + m_div;
          m_left = OS;
        end
      end else if (!en) begin
        m_run = 0;
        if (m_pv) m_div = m_pend;
        m_pv = 0;
        if (acc) begin
          if (legal) m_div = int'(cfg_div); else e_err = 1;
        end
      end else begin
        if (cyc == m_next) begin
          if (m_pv) begin m_div = m_pend; m_pv = 0; end
          if (!sync_req) begin
            e_os = 1;
            if (m_left == 1) begin e_bit = 1; m_left = OS; end
            else m_left--;
          end
        end
        if (sync_req) begin
          m_next = cyc + m_div;
          m_left = OS / 2;
        end else if (cyc == m_next) begin
          m_next = cyc + m_div;
        end
        if (acc) begin
          if (legal) begin m_pend = int'(cfg_div); m_pv = 1; end
          else e_err = 1;
        end
      end
      e_ready = !m_pv;
      e_busy  = m_run;
      if (e_os) e_dclk = !e_dclk;
    end
    #1;
    chk("os_tick",    32'(os_tick),    32'(e_os));
    chk("bit_tick",   32'(bit_tick),   32'(e_bit));
    chk("cfg_err",    32'(cfg_err),    32'(e_err));
    chk("cfg_ready",  32'(cfg_ready),  32'(e_ready));
    chk("busy",       32'(busy),       32'(e_busy));
    chk("active_div", 32'(active_div), 32'(m_div));
`ifdef BAUD_DIVCLK_EN
    chk("div_clk",    32'(div_clk),    32'(e_dclk));
`endif
  end

  initial begin
    rst_n = 0; en = 0; cfg_valid = 0; cfg_div = '0; sync_req = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_active_div", 32'(active_div), 32'd4);
    chk("rst_cfg_ready",  32'(cfg_ready),  32'd1);
    chk("rst_os_tick",    32'(os_tick),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);

    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);

    // Illegal divisor 0 offered in IDLE.
    cfg_valid = 1; cfg_div = CW'(0);
    @(posedge clk); #2;
    chk("idle_div0_err", 32'(cfg_err),    32'd1);
    chk("idle_div0_div", 32'(active_div), 32'd4);
    @(negedge clk) cfg_valid = 0;
    @(posedge clk); #2;
    chk("err_one_cycle", 32'(cfg_err), 32'd0);

    // First tick 4 edges after en is taken, bit tick on the 4th os_tick.
    @(negedge clk) en = 1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #2;
      chk("first_os",  32'(os_tick),  32'((k > 0 && (k % 4) == 0) ? 1 : 0));
      chk("first_bit", 32'(bit_tick), 32'((k == 16) ? 1 : 0));
    end

    // Illegal divisor 1 offered in RUN.
    @(negedge clk) begin cfg_valid = 1; cfg_div = CW'(1); end
    @(posedge clk); #2;
    chk("run_div1_err", 32'(cfg_err),    32'd1);
    chk("run_div1_div", 32'(active_div), 32'd4);

    // Pending divisor flushed by dropping en.
    @(negedge clk) cfg_div = CW'(8);
    @(posedge clk); #2;
    chk("pend_ready_low", 32'(cfg_ready), 32'd0);
    @(negedge clk) begin cfg_valid = 0; en = 0; end
    @(posedge clk); #2;
    chk("stop_busy",  32'(busy),       32'd0);
    chk("stop_div",   32'(active_div), 32'd8);
    chk("stop_ready", 32'(cfg_ready),  32'd1);
    chk("stop_os",    32'(os_tick),    32'd0);

    // Reset in PEND drops the pending value.
    @(negedge clk) en = 1;
    repeat (2) @(negedge clk);
    cfg_valid = 1; cfg_div = CW'(3);
    @(negedge clk) begin cfg_valid = 0; rst_n = 0; end
    @(posedge clk); #2;
    chk("rst_pend_div",   32'(active_div), 32'd4);
    chk("rst_pend_ready", 32'(cfg_ready),  32'd1);
    chk("rst_pend_busy",  32'(busy),       32'd0);
    @(negedge clk) begin rst_n = 1; en = 0; end

    // Randomized run checked by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1;
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_div   = CW'($urandom_range(0, 9));
      sync_req  = ($urandom_range(0, 29) == 0);
      rst_n     = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk) begin cfg_valid = 0; sync_req = 0; rst_n = 1; end
    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
